// File: rtl/decode38_pkg.sv
// decode38_pkg: seven-segment constants and code-to-segment helper shared by
// the 3-to-8 chaser and its 8-to-3 encoder counterpart.
// Patterns are active-low, bit order {g,f,e,d,c,b,a}.
package decode38_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg7(input logic [2:0] v);
    logic [6:0] s;
    case (v)
      3'd0:    s = SEG_0;
      3'd1:    s = SEG_1;
      3'd2:    s = SEG_2;
      3'd3:    s = SEG_3;
      3'd4:    s = SEG_4;
      3'd5:    s = SEG_5;
      3'd6:    s = SEG_6;
      default: s = SEG_7;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/decode38_chaser_tick_gen.sv
// tick_gen: prescaler producing a one-cycle tick every DIV enabled cycles.
// clr restarts the count; dropping ena also clears it so the first tick after
// ena rises always comes a full DIV cycles later.
module tick_gen #(
  parameter int DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic ena,
  output logic tick
);

  localparam int               PRE_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  logic [PRE_W-1:0] pre_q, pre_d;

  assign tick = ena & (pre_q == PRE_LAST);

  // next prescaler value: clear on load, disable or terminal count, else count
  always_comb begin
    pre_d = pre_q + PRE_W'(1);
    if (clr || !ena || tick) begin
      pre_d = '0;
    end
  end

  // prescaler register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/decode38_chaser.sv
// decode38_chaser: registered 3-bit code, loadable or auto-stepped, shown as
// a one-hot 8-LED running light and an active-low 7-segment digit.
// Optional macro DECODE38_CHASER_BOUNCE_EN turns the modulo-8 up-count into a
// ping-pong sweep with a direction flop; the port list is the same either way.
module decode38_chaser
  import decode38_pkg::*;
#(
  parameter int DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [2:0] code,
  input  logic       load,
  input  logic       run,
  output logic [7:0] y,
  output logic [2:0] cur,
  output logic       wrap,
  output logic [6:0] HEX
);

  logic [2:0] cur_q, cur_d;
  logic       wrap_q, wrap_d;
  logic       tick;

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (load),
    .ena  (en & run),
    .tick (tick)
  );

`ifdef DECODE38_CHASER_BOUNCE_EN
  logic       dir_q, dir_d;
  logic       go_up;
  logic [2:0] nxt;

  // ping-pong step: ends force the direction so a load to 7 or 0 still turns
  always_comb begin
    cur_d  = cur_q;
    wrap_d = 1'b0;
    dir_d  = dir_q;
    if (cur_q == 3'd0) begin
      go_up = 1'b1;
    end else if (cur_q == 3'd7) begin
      go_up = 1'b0;
    end else begin
      go_up = ~dir_q;
    end
    nxt = go_up ? (cur_q + 3'd1) : (cur_q - 3'd1);
    if (load) begin
      cur_d = code;
      dir_d = 1'b0;
    end else if (tick) begin
      cur_d  = nxt;
      wrap_d = (nxt == 3'd7) || (nxt == 3'd0);
      dir_d  = (nxt == 3'd7) || (!go_up && (nxt != 3'd0));
    end
  end

  // direction register, 0 = counting up
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q <= 1'b0;
    end else begin
      dir_q <= dir_d;
    end
  end
`else
  // modulo-8 up-step; load wins over a coincident tick and kills its wrap
  always_comb begin
    cur_d  = cur_q;
    wrap_d = 1'b0;
    if (load) begin
      cur_d = code;
    end else if (tick) begin
      cur_d  = cur_q + 3'd1;
      wrap_d = (cur_q == 3'd7);
    end
  end
`endif

  // code and wrap-pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q  <= 3'd0;
      wrap_q <= 1'b0;
    end else begin
      cur_q  <= cur_d;
      wrap_q <= wrap_d;
    end
  end

  assign cur  = cur_q;
  assign wrap = wrap_q;
  assign y    = en ? (8'b0000_0001 << cur_q) : 8'b0000_0000;
  assign HEX  = en ? seg7(cur_q) : SEG_BLANK;

endmodule

// File: tb/tb_decode38_chaser.sv
// Testbench for decode38_chaser: a DIV=4 and a DIV=1 instance share the same
// stimulus and are compared against a cycle-count reference model.
module tb_decode38_chaser;

  logic       clk = 1'b0;
  logic       rst_n, en, load, run;
  logic [2:0] code;
  logic [7:0] y4, y1;
  logic [2:0] cur4, cur1;
  logic       wrap4, wrap1;
  logic [6:0] hex4, hex1;

  int errors = 0;
  int checks = 0;

  int m_cur  [2];
  int m_cnt  [2];
  int m_wrap [2];
  int divs   [2] = '{4, 1};
  logic [6:0] seg_ref [8] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000};

  always #5 clk = ~clk;

  decode38_chaser #(.DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .code(code), .load(load), .run(run),
    .y(y4), .cur(cur4), .wrap(wrap4), .HEX(hex4)
  );

  decode38_chaser #(.DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .code(code), .load(load), .run(run),
    .y(y1), .cur(cur1), .wrap(wrap1), .HEX(hex1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cur[i]  = 0;
      m_cnt[i]  = 0;
      m_wrap[i] = 0;
    end
  endtask

  // one clock edge of the reference: count enabled cycles, step every DIV-th
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      int w;
      w = 0;
      if (!rst_n) begin
        m_cur[i] = 0;
        m_cnt[i] = 0;
      end else if (load) begin
        m_cur[i] = int'(code);
        m_cnt[i] = 0;
      end else if (en && run) begin
        m_cnt[i] = m_cnt[i] + 1;
        if (m_cnt[i] == divs[i]) begin
          m_cnt[i] = 0;
          w = (m_cur[i] == 7) ? 1 : 0;
          m_cur[i] = (m_cur[i] + 1) % 8;
        end
      end else begin
        m_cnt[i] = 0;
      end
      m_wrap[i] = w;
    end
  endtask

  task automatic check_all();
    chk("cur4",  cur4,  m_cur[0]);
    chk("y4",    y4,    en ? (1 << m_cur[0]) : 0);
    chk("hex4",  hex4,  en ? seg_ref[m_cur[0]] : 7'h7f);
    chk("wrap4", wrap4, m_wrap[0]);
    chk("cur1",  cur1,  m_cur[1]);
    chk("y1",    y1,    en ? (1 << m_cur[1]) : 0);
    chk("hex1",  hex1,  en ? seg_ref[m_cur[1]] : 7'h7f);
    chk("wrap1", wrap1, m_wrap[1]);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // called just after a checked edge; reset lands between clock edges
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("areset_cur4", cur4, 0);
    chk("areset_cur1", cur1, 0);
    check_all();
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1; en = 1'b0; run = 1'b0; load = 1'b0; code = 3'd0;
    model_reset();
    #1 rst_n = 1'b0;
    #1 check_all();
    cycle();
    cycle();
    rst_n = 1'b1;

    // idle display at code 0
    en = 1'b1;
    repeat (20) cycle();

    // single-cycle load, holds while run=0
    load = 1'b1; code = 3'd5;
    cycle();
    load = 1'b0;
    chk("load5_cur", cur4, 5);
    chk("load5_hex", hex4, 7'b0010010);
    repeat (5) cycle();

    // load 6, run: 7 after four cycles, 0 with one wrap after four more
    load = 1'b1; code = 3'd6;
    cycle();
    load = 1'b0; run = 1'b1;
    repeat (4) cycle();
    chk("step_to7", cur4, 7);
    repeat (4) cycle();
    chk("wrap_cur0", cur4, 0);
    chk("wrap_pulse", wrap4, 1);
    chk("wrap_y", y4, 8'b0000_0001);
    cycle();
    chk("wrap_once", wrap4, 0);

    // load on the terminal-count cycle beats the step
    repeat (2) cycle();
    load = 1'b1; code = 3'd2;
    cycle();
    load = 1'b0;
    chk("ld_tick_cur", cur4, 2);
    chk("ld_tick_wrap", wrap4, 0);
    repeat (3) cycle();
    chk("ld_tick_hold", cur4, 2);
    cycle();
    chk("ld_tick_next", cur4, 3);

    // en=0 blanks, freezes, still loads; resumes a full period later
    en = 1'b0;
    repeat (3) cycle();
    chk("en0_y", y4, 0);
    chk("en0_hex", hex4, 7'h7f);
    load = 1'b1; code = 3'd4;
    cycle();
    load = 1'b0;
    chk("en0_load", cur4, 4);
    en = 1'b1;
    #1 chk("en1_y", y4, 8'b0001_0000);
    repeat (3) cycle();
    chk("en1_hold", cur4, 4);
    cycle();
    chk("en1_step", cur4, 5);

    // DIV=1 steps every clock, one wrap on 7->0
    load = 1'b1; code = 3'd0;
    cycle();
    load = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cycle();
      chk("div1_seq", cur1, k % 8);
      chk("div1_wrap", wrap1, (k == 8) ? 1 : 0);
    end
    repeat (3) cycle();
    async_reset();

    // randomized traffic
    for (int n = 0; n < 500; n++) begin
      en   = ($urandom_range(0, 9) != 0);
      run  = ($urandom_range(0, 7) != 0);
      load = ($urandom_range(0, 11) == 0);
      code = 3'($urandom);
      if ($urandom_range(0, 59) == 0) begin
        async_reset();
      end else begin
        cycle();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
